serv_mac_datapath: RTL and testbench
====================================

Name: serv_mac_datapath

Overview:
- Bit-serial (W=1) multiply-accumulate datapath for the two-phase MAC custom instruction.
- Acts as the execute-side responder to the MAC PC sequencer. During repeated MAC_step1 passes it loads operands and then runs shift-add iterations. It reports o_mac_more, which tells the sequencer whether to replay the step1 instruction.
- During the MAC_step2 pass it streams the 32-bit accumulator out on o_rd.
- Sits beside serv_alu. It uses the core's serial counter strobes (cnt_en/cnt0/cnt_done) and the serial rs1/rs2 buses.

Parameters:
- W, 1, serial datapath width; only 1 supported.
- B, W-1, MSB index of serial buses.
- XLEN, 32, operand and accumulator width; also the iteration count.

Ports:
- clk  input  1  core clock
- i_rst_n  input  1  asynchronous active-low reset
- i_init  input  1  init phase of a two-phase instruction; passes are only counted when low
- i_cnt_en  input  1  serial bit strobe; one bit of each bus is valid per strobe
- i_cnt0  input  1  first bit of a pass
- i_cnt_done  input  1  last bit of a pass
- i_MAC_step1  input  1  decoded MAC step1 instruction
- i_MAC_step2  input  1  decoded MAC step2 instruction
- i_acc_clr  input  1  clear accumulator at end of step2 pass
- i_rs1  input  W  serial rs1, LSB first (multiplier)
- i_rs2  input  W  serial rs2, LSB first (multiplicand)
- o_rd  output  W  serial result bit (accumulator LSB during step2 pass, else 0)
- o_mac_more  output  1  step1 must be replayed (feeds PC sequencer compare input)
- o_busy  output  1  iteration in progress (load done, iterations incomplete)

Behaviour:
- Reset (async, i_rst_n low):
  - acc, mier, mcand, carry cleared; iter=0.
  - o_rd=0, o_mac_more=1, o_busy=0.
  - Reset mid-pass aborts immediately; no partial state survives.
- Pass definition:
  - A pass is the sequence of i_cnt_en cycles from i_cnt0 to i_cnt_done with i_init low.
  - cnt_en cycles with i_init high are ignored.
- Iteration counter: iter, 6 bits, values 0..XLEN+1.
- LOAD state (step1 pass, iter==0):
  - Each cnt_en: mier <= {i_rs1, mier[31:1]}, mcand <= {i_rs2, mcand[31:1]}.
  - acc rotates unchanged.
  - At cnt_done: iter <= 1.
- ITER state (step1 pass, 1 <= iter <= XLEN):
  - Each cnt_en: addend = mier[0] & mcand[0]; {carry, s} = acc[0] + addend + carry.
  - acc <= {s, acc[31:1]}; mcand rotates right by 1.
  - carry is forced to 0 on the i_cnt0 cycle before the add.
  - At cnt_done: mier >>= 1 (zero fill); mcand <<= 1 (parallel, zero fill); iter += 1.
  - Final carry out of bit 31 is discarded: result is modulo 2^32.
- DONE state (step1 pass, iter==XLEN+1):
  - A further step1 pass is a no-op; acc rotates unchanged.
- o_mac_more:
  - Combinational: high while iter <= XLEN.
  - Sampled by the sequencer during the init phase to decide on replay.
- o_busy: high while 1 <= iter <= XLEN.
- Step2 pass:
  - o_rd = acc[0] on each cnt_en; acc rotates unchanged.
  - At cnt_done: iter <= 0, mier/mcand cleared, acc cleared if i_acc_clr.
  - o_rd=0 outside step2 cnt_en cycles.
- Simultaneous/illegal inputs:
  - i_MAC_step1 and i_MAC_step2 both high: step2 takes priority.
  - Step2 while iter in 1..XLEN: result is the partial sum; iter still returns to 0.
- Accumulation:
  - acc persists across instructions, so consecutive MACs sum (acc += rs1*rs2).
- Latency:
  - One MAC = 1 load pass + 32 iteration passes + 1 step2 pass.
  - o_rd is valid in the same cycle as its cnt_en.

Decomposition:
- Shared package (serv_mac_pkg): XLEN, ITER_W=6, state encodings LOAD/ITER/DONE derived from iter, used by the sequencer and this block.
- One natural sub-module: serv_mac_bitadd, the 1-bit full adder with carry register cleared on cnt0.

Test Plan:
- rs1=3, rs2=5, acc=0: full step1 loop, then step2 -> o_rd streams 15 (0x0000000F) LSB first; o_mac_more falls after pass 33.
- Two back-to-back MACs (7*6, then 2*10) without clear -> step2 reads 62; third with i_acc_clr=1 yields acc=0 afterwards.
- rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> o_rd = 0x00000001 (mod 2^32 wrap).
- i_rst_n asserted during iteration pass 10 -> all outputs at reset values immediately; next MAC 4*4 -> 16.
- Step1 and step2 asserted together with acc=0x12345678 -> o_rd = 0x12345678; iter returns to 0.
- cnt_en with i_init high during all passes -> no state change (acc, iter unchanged).

Source files
------------

// File: rtl/serv_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serv_mac_pkg
//  Brief    : Shared constants, iteration type and LOAD/ITER/DONE decode for
//             the bit-serial MAC datapath and its PC sequencer.
//  Revision : 1.0
// ============================================================================
package serv_mac_pkg;

    localparam int XLEN   = 32;
    localparam int ITER_W = 6;

    typedef logic [ITER_W-1:0] iter_t;

    localparam logic [1:0] c_ST_LOAD = 2'd0;
    localparam logic [1:0] c_ST_ITER = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Phase is implied by the iteration count: 0 load, 1..XLEN add, XLEN+1 done
    function automatic logic [1:0] mac_state(input iter_t iter);
        logic [1:0] st;
        if (iter == '0)
            st = c_ST_LOAD;
        else if (iter <= iter_t'(XLEN))
            st = c_ST_ITER;
        else
            st = c_ST_DONE;
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serv_mac_bitadd.sv
`default_nettype none
// ============================================================================
//  Module   : serv_mac_bitadd
//  Brief    : 1-bit serial full adder; carry register is ignored on the first
//             bit of a pass so each pass starts a fresh 32-bit add.
//  Revision : 1.0
// ============================================================================
module serv_mac_bitadd (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_a,
    input  logic i_b,
    output logic o_s
);

    logic r_carry;
    logic w_cin;
    logic w_cout;

    assign w_cin           = i_clr ? 1'b0 : r_carry;
    assign {w_cout, o_s}   = {1'b0, i_a} + {1'b0, i_b} + {1'b0, w_cin};

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_carry <= 1'b0;
        else if (i_en)
            r_carry <= w_cout;
    end

endmodule
`default_nettype wire

// File: rtl/serv_mac_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : serv_mac_datapath
//  Brief    : Bit-serial shift-add multiply-accumulate for the two-phase MAC
//             instruction; step1 passes load/iterate, step2 streams acc out.
//  Revision : 1.0
// ============================================================================
module serv_mac_datapath #(
    parameter int W    = 1,
    parameter int B    = W - 1,
    parameter int XLEN = serv_mac_pkg::XLEN
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_init,
    input  logic         i_cnt_en,
    input  logic         i_cnt0,
    input  logic         i_cnt_done,
    input  logic         i_MAC_step1,
    input  logic         i_MAC_step2,
    input  logic         i_acc_clr,
    input  logic [B:0]   i_rs1,
    input  logic [B:0]   i_rs2,
    output logic [B:0]   o_rd,
    output logic         o_mac_more,
    output logic         o_busy
);

    import serv_mac_pkg::*;

    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mier;
    logic [XLEN-1:0] r_mcand;
    iter_t           r_iter;

    logic            w_active;
    logic            w_step1;
    logic            w_step2;
    logic [1:0]      w_state;
    logic            w_load;
    logic            w_iter;
    logic            w_addend;
    logic            w_sum;
    logic [XLEN-1:0] w_acc_rot;

    // Init-phase strobes belong to the sequencer, never to this datapath
    assign w_active  = i_cnt_en & ~i_init;
    assign w_step2   = w_active & i_MAC_step2;
    assign w_step1   = w_active & i_MAC_step1 & ~i_MAC_step2;
    assign w_state   = mac_state(r_iter);
    assign w_load    = w_step1 & (w_state == c_ST_LOAD);
    assign w_iter    = w_step1 & (w_state == c_ST_ITER);
    assign w_addend  = r_mier[0] & r_mcand[0];
    assign w_acc_rot = {r_acc[0], r_acc[XLEN-1:1]};

    assign o_rd       = w_step2 & r_acc[0];
    assign o_mac_more = (w_state != c_ST_DONE);
    assign o_busy     = (w_state == c_ST_ITER);

    serv_mac_bitadd u_bitadd (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_iter),
        .i_clr   (i_cnt0),
        .i_a     (r_acc[0]),
        .i_b     (w_addend),
        .o_s     (w_sum)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc   <= '0;
            r_mier  <= '0;
            r_mcand <= '0;
            r_iter  <= '0;
        end else if (w_step2) begin
            if (i_cnt_done) begin
                r_acc   <= i_acc_clr ? '0 : w_acc_rot;
                r_mier  <= '0;
                r_mcand <= '0;
                r_iter  <= '0;
            end else begin
                r_acc   <= w_acc_rot;
            end
        end else if (w_load) begin
            r_acc   <= w_acc_rot;
            r_mier  <= {i_rs1[0], r_mier[XLEN-1:1]};
            r_mcand <= {i_rs2[0], r_mcand[XLEN-1:1]};
            if (i_cnt_done)
                r_iter <= iter_t'(1);
        end else if (w_iter) begin
            r_acc <= {w_sum, r_acc[XLEN-1:1]};
            if (i_cnt_done) begin
                // Last bit of the pass: the rotation is complete, so shifting
                // the rotated value left equals dropping the top bit in place.
                r_mier  <= {1'b0, r_mier[XLEN-1:1]};
                r_mcand <= {r_mcand[XLEN-1:1], 1'b0};
                r_iter  <= r_iter + iter_t'(1);
            end else begin
                r_mcand <= {r_mcand[0], r_mcand[XLEN-1:1]};
            end
        end else if (w_step1) begin
            r_acc <= w_acc_rot;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serv_mac_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serv_mac_datapath
//  Brief    : Directed-vector bench for serv_mac_datapath.
//  Revision : 1.0
// ============================================================================
module tb_serv_mac_datapath;

    logic clk = 1'b0;
    logic i_rst_n;
    logic i_init, i_cnt_en, i_cnt0, i_cnt_done;
    logic i_MAC_step1, i_MAC_step2, i_acc_clr;
    logic [0:0] i_rs1, i_rs2, o_rd;
    logic o_mac_more, o_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serv_mac_datapath dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_init      (i_init),
        .i_cnt_en    (i_cnt_en),
        .i_cnt0      (i_cnt0),
        .i_cnt_done  (i_cnt_done),
        .i_MAC_step1 (i_MAC_step1),
        .i_MAC_step2 (i_MAC_step2),
        .i_acc_clr   (i_acc_clr),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .o_rd        (o_rd),
        .o_mac_more  (o_mac_more),
        .o_busy      (o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        i_cnt_en    = 1'b0;
        i_cnt0      = 1'b0;
        i_cnt_done  = 1'b0;
        i_init      = 1'b0;
        i_MAC_step1 = 1'b0;
        i_MAC_step2 = 1'b0;
        i_acc_clr   = 1'b0;
        i_rs1       = 1'b0;
        i_rs2       = 1'b0;
    endtask

    task automatic do_pass(input logic s1, input logic s2, input logic init, input logic clr,
                           input logic [31:0] a, input logic [31:0] b, output logic [31:0] rd);
        rd = '0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            i_cnt_en    = 1'b1;
            i_cnt0      = (i == 0);
            i_cnt_done  = (i == 31);
            i_init      = init;
            i_MAC_step1 = s1;
            i_MAC_step2 = s2;
            i_acc_clr   = clr;
            i_rs1       = a[i];
            i_rs2       = b[i];
            #1 rd[i] = o_rd[0];
        end
        @(negedge clk);
        idle();
    endtask

    // Replays step1 while o_mac_more is high, as the sequencer does
    task automatic run_mac(input logic [31:0] a, input logic [31:0] b, input logic dummy,
                           output int passes);
        logic [31:0] junk;
        passes = 0;
        while (o_mac_more && passes < 40) begin
            if (dummy)
                do_pass(1'b1, 1'b0, 1'b1, 1'b0, ~a, ~b, junk);
            do_pass(1'b1, 1'b0, 1'b0, 1'b0, a, b, junk);
            passes++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          passes;

        idle();
        i_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd",   32'(o_rd),       32'd0);
        chk("rst_more", 32'(o_mac_more), 32'd1);
        chk("rst_busy", 32'(o_busy),     32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;

        // 3 * 5
        do_pass(1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'd5, rd);
        chk("load_busy", 32'(o_busy), 32'd1);
        run_mac(32'd3, 32'd5, 1'b0, passes);
        chk("3x5_passes", 32'(passes + 1), 32'd33);
        chk("3x5_more",   32'(o_mac_more), 32'd0);
        chk("3x5_busy",   32'(o_busy),     32'd0);
        do_pass(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, rd);
        chk("3x5_rd",     rd, 32'h0000000F);
        chk("post_more",  32'(o_mac_more), 32'd1);

        // Accumulation without clear, then a clearing step2
        run_mac(32'd7, 32'd6, 1'b0, passes);
        do_pass(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, rd);
        chk("7x6_rd", rd, 32'd42);
        run_mac(32'd2, 32'd10, 1'b0, passes);
        chk("2x10_passes", 32'(passes), 32'd33);
        do_pass(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, rd);
        chk("acc62_rd", rd, 32'd62);
        run_mac(32'd1, 32'd1, 1'b0, passes);
        do_pass(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, rd);
        chk("acc63_rd", rd, 32'd63);
        do_pass(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, rd);
        chk("cleared_rd", rd, 32'd0);

        // Modulo 2^32 wrap
        run_mac(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, passes);
        do_pass(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, rd);
        chk("wrap_rd", rd, 32'h00000001);

        // Reset in the middle of iteration pass 10
        for (int p = 0; p < 10; p++)
            do_pass(1'b1, 1'b0, 1'b0, 1'b0, 32'h000000FF, 32'd3, rd);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            i_cnt_en    = 1'b1;
            i_cnt0      = (i == 0);
            i_MAC_step1 = 1'b1;
            i_rs1       = 1'b1;
            i_rs2       = 1'b1;
        end
        #1 chk("pre_rst_busy", 32'(o_busy), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_more", 32'(o_mac_more), 32'd1);
        chk("mid_rst_busy", 32'(o_busy),     32'd0);
        chk("mid_rst_rd",   32'(o_rd),       32'd0);
        @(negedge clk);
        idle();
        @(negedge clk);
        i_rst_n = 1'b1;
        run_mac(32'd4, 32'd4, 1'b0, passes);
        do_pass(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, rd);
        chk("4x4_rd", rd, 32'd16);

        // Step1 and step2 together: step2 wins and iter returns to 0
        run_mac(32'h12345678, 32'd1, 1'b0, passes);
        do_pass(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, rd);
        chk("seed_rd", rd, 32'h12345678);
        do_pass(1'b1, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9, rd);
        chk("both_pre_busy", 32'(o_busy), 32'd1);
        do_pass(1'b1, 1'b1, 1'b0, 1'b0, 32'd9, 32'd9, rd);
        chk("both_rd",   rd, 32'h12345678);
        chk("both_busy", 32'(o_busy),     32'd0);
        chk("both_more", 32'(o_mac_more), 32'd1);

        // Init-phase strobes are ignored throughout
        do_pass(1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 32'd0, rd);
        chk("init_s2_rd", rd, 32'd0);
        do_pass(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, rd);
        chk("init_s1_busy", 32'(o_busy), 32'd0);
        run_mac(32'd5, 32'd7, 1'b1, passes);
        chk("init_passes", 32'(passes), 32'd33);
        do_pass(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, rd);
        chk("init_acc_rd", rd, 32'h1234569B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
